// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: BHT counter states, operation priority
// and the PC-to-BHT index mapping.
package branch_pkg;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;
  localparam logic [1:0] CNT_RST = CNT_WNT;

  // Enumeration order mirrors decode priority, highest first.
  typedef enum logic [3:0] {
    OP_NONE,
    OP_JALR,
    OP_JAL,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU
  } op_e;

  // Word-aligned PC bits select the counter; depth must be a power of two.
  function automatic logic [31:0] bht_index(input logic [31:0] pc, input int depth);
    return (pc >> 2) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Table of 2-bit saturating counters: combinational prediction read,
// one synchronous update per cycle, asynchronous reset to weakly not-taken.
module branch_bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt_q [DEPTH];

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
  endfunction

  // Read sees the stored value, so a same-cycle update is not forwarded.
  assign rd_pred = cnt_q[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= sat_step(cnt_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_unit.sv
// EX-stage branch resolution with BHT prediction and registered fetch redirect.
// Optional BRANCH_STATS_EN adds branch / mispredict counters.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  input  logic            ex_valid_i,
  input  logic            flush_i,
  input  logic            beq_i,
  input  logic            bne_i,
  input  logic            blt_i,
  input  logic            bge_i,
  input  logic            bltu_i,
  input  logic            bgeu_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_pred_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] link_o,
  output logic            taken_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // ---- stage p0: decode, compare, target (combinational in EX) ----
  logic vld_p0;
  op_e  op_p0;
  assign vld_p0 = ex_valid_i & ~flush_i;

  always_comb begin
    op_p0 = OP_NONE;
    if      (jalr_i) op_p0 = OP_JALR;
    else if (jal_i)  op_p0 = OP_JAL;
    else if (beq_i)  op_p0 = OP_BEQ;
    else if (bne_i)  op_p0 = OP_BNE;
    else if (blt_i)  op_p0 = OP_BLT;
    else if (bge_i)  op_p0 = OP_BGE;
    else if (bltu_i) op_p0 = OP_BLTU;
    else if (bgeu_i) op_p0 = OP_BGEU;
  end

  logic signed [XLEN-1:0] rs1_s_p0, rs2_s_p0;
  logic eq_p0, lt_s_p0, lt_u_p0;
  assign rs1_s_p0 = rs1_i;
  assign rs2_s_p0 = rs2_i;
  assign eq_p0    = (rs1_i == rs2_i);
  assign lt_s_p0  = (rs1_s_p0 < rs2_s_p0);
  assign lt_u_p0  = (rs1_i < rs2_i);

  logic taken_p0, cond_p0, jump_p0;
  always_comb begin
    taken_p0 = 1'b0;
    cond_p0  = 1'b0;
    jump_p0  = 1'b0;
    case (op_p0)
      OP_JALR, OP_JAL: begin jump_p0 = 1'b1; taken_p0 = 1'b1; end
      OP_BEQ:  begin cond_p0 = 1'b1; taken_p0 = eq_p0;    end
      OP_BNE:  begin cond_p0 = 1'b1; taken_p0 = ~eq_p0;   end
      OP_BLT:  begin cond_p0 = 1'b1; taken_p0 = lt_s_p0;  end
      OP_BGE:  begin cond_p0 = 1'b1; taken_p0 = ~lt_s_p0; end
      OP_BLTU: begin cond_p0 = 1'b1; taken_p0 = lt_u_p0;  end
      OP_BGEU: begin cond_p0 = 1'b1; taken_p0 = ~lt_u_p0; end
      default: ;
    endcase
  end

  logic [XLEN-1:0] br_tgt_p0, jalr_sum_p0, target_p0, link_p0, redir_pc_p0;
  logic            mispred_p0, redirect_p0;
  assign br_tgt_p0   = ex_pc_i + imm_i;
  assign jalr_sum_p0 = rs1_i + imm_i;
  assign target_p0   = (op_p0 == OP_JALR) ? (jalr_sum_p0 & ~XLEN'(1)) : br_tgt_p0;
  assign link_p0     = ex_pc_i + XLEN'(4);
  assign mispred_p0  = cond_p0 & (taken_p0 != ex_pred_i);
  assign redirect_p0 = vld_p0 & (jump_p0 | mispred_p0);
  assign redir_pc_p0 = taken_p0 ? target_p0 : link_p0;

  branch_bht #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (IDX_W'(bht_index(32'(if_pc_i), BHT_DEPTH))),
    .rd_pred  (if_pred_taken_o),
    .wr_en    (vld_p0 & cond_p0),
    .wr_idx   (IDX_W'(bht_index(32'(ex_pc_i), BHT_DEPTH))),
    .wr_taken (taken_p0)
  );

  // ---- stage p1: registered resolution to fetch / writeback ----
  logic            redirect_p1, taken_p1;
  logic [XLEN-1:0] redirect_pc_p1, link_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_p1    <= 1'b0;
      taken_p1       <= 1'b0;
      redirect_pc_p1 <= '0;
      link_p1        <= '0;
    end else begin
      redirect_p1 <= redirect_p0;
      taken_p1    <= vld_p0 & taken_p0;
      if (vld_p0) begin
        redirect_pc_p1 <= redir_pc_p0;
        link_p1        <= link_p0;
      end
    end
  end

  assign redirect_o    = redirect_p1;
  assign taken_o       = taken_p1;
  assign redirect_pc_o = redirect_pc_p1;
  assign link_o        = link_p1;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (vld_p0 & cond_p0) begin
      stat_br_q <= stat_br_q + 32'd1;
      if (mispred_p0) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end
  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: driver queues expected results, a negedge
// monitor pops and compares them one cycle later.
module tb_branch_unit;

  localparam logic [7:0] S_JALR = 8'h80, S_JAL = 8'h40, S_BEQ = 8'h20, S_BNE = 8'h10;
  localparam logic [7:0] S_BLT  = 8'h08, S_BGE = 8'h04, S_BLTU = 8'h02, S_BGEU = 8'h01;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] if_pc_i = '0, ex_pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
  logic        ex_valid_i = 1'b0, flush_i = 1'b0, ex_pred_i = 1'b0;
  logic        beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i, jal_i, jalr_i;
  logic [7:0]  sel = '0;
  logic        if_pred_taken_o, redirect_o, taken_o;
  logic [31:0] redirect_pc_o, link_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  assign {jalr_i, jal_i, beq_i, bne_i, blt_i, bge_i, bltu_i, bgeu_i} = sel;

  branch_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc_i(if_pc_i), .if_pred_taken_o(if_pred_taken_o),
    .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .beq_i(beq_i), .bne_i(bne_i), .blt_i(blt_i), .bge_i(bge_i),
    .bltu_i(bltu_i), .bgeu_i(bgeu_i), .jal_i(jal_i), .jalr_i(jalr_i),
    .ex_pc_i(ex_pc_i), .ex_pred_i(ex_pred_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .link_o(link_o), .taken_o(taken_o)
`ifdef BRANCH_STATS_EN
    , .stat_branches_o(stat_branches_o), .stat_mispredicts_o(stat_mispredicts_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        redir;
    logic        taken;
    logic        chk_pc;
    logic        chk_link;
    logic [31:0] rpc;
    logic [31:0] link;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: each queued entry is due the cycle after it was issued.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e;
      e = q.pop_front();
      check("redirect", 32'(redirect_o), 32'(e.redir));
      check("taken", 32'(taken_o), 32'(e.taken));
      if (e.chk_pc)   check("redirect_pc", redirect_pc_o, e.rpc);
      if (e.chk_link) check("link", link_o, e.link);
    end
  end

  task automatic idle();
    exp_t e;
    @(negedge clk);
    ex_valid_i = 1'b0; flush_i = 1'b0; sel = '0;
    e = '{cyc: cyc, redir: 1'b0, taken: 1'b0, chk_pc: 1'b0, chk_link: 1'b0, rpc: '0, link: '0};
    q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] s, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic pred,
                       input logic fl, input logic er, input logic [31:0] erpc,
                       input logic [31:0] elink, input logic et);
    exp_t e;
    @(negedge clk);
    ex_valid_i = 1'b1; flush_i = fl; sel = s;
    ex_pc_i = pc; rs1_i = a; rs2_i = b; imm_i = imm; ex_pred_i = pred;
    e = '{cyc: cyc, redir: er, taken: et, chk_pc: er, chk_link: ~fl, rpc: erpc, link: elink};
    q.push_back(e);
  endtask

  task automatic check_pred(input logic [31:0] pc, input logic exp);
    idle();
    if_pc_i = pc;
    #1;
    check($sformatf("pred@%08h", pc), 32'(if_pred_taken_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_pc_i = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check("pred_after_reset", 32'(if_pred_taken_o), 32'd0);
    check("reset_redirect", 32'(redirect_o), 32'd0);
    check("reset_taken", 32'(taken_o), 32'd0);
    check("reset_rpc", redirect_pc_o, 32'd0);
    check("reset_link", link_o, 32'd0);
`ifdef BRANCH_STATS_EN
    check("reset_stat_br", stat_branches_o, 32'd0);
    check("reset_stat_mis", stat_mispredicts_o, 32'd0);
`endif
    rst_n = 1'b1;
    idle();

    // beq taken with not-taken prediction; same-cycle lookup sees old counter
    issue(S_BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 1'b1, 32'h120, 32'h104, 1'b1);
    if_pc_i = 32'h100;
    #1;
    check("pred_same_cycle", 32'(if_pred_taken_o), 32'd0);
    check_pred(32'h100, 1'b1);

    // signed vs unsigned compare on the same operands
    issue(S_BLT,  32'h304, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h344, 32'h308, 1'b1);
    issue(S_BLTU, 32'h308, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h30C, 32'h30C, 1'b0);

    // jalr clears bit 0 and leaves the BHT alone (idx 5 stays weakly not-taken)
    issue(S_JALR, 32'h414, 32'h1003, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1002, 32'h418, 1'b1);
    check_pred(32'h414, 1'b0);
    issue(S_JAL, 32'h500, 32'd0, 32'd0, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b1, 32'h400, 32'h504, 1'b1);

    // counter at 0x208 starts at 0 (decremented by bltu); four taken saturate at 3
    check_pred(32'h208, 1'b0);
    for (int i = 0; i < 4; i++)
      issue(S_BEQ, 32'h208, 32'd7, 32'd7, 32'h10, 1'b1, 1'b0, 1'b0, 32'h218, 32'h20C, 1'b1);
    check_pred(32'h208, 1'b1);
    issue(S_BNE, 32'h208, 32'd7, 32'd7, 32'h10, 1'b1, 1'b0, 1'b1, 32'h20C, 32'h20C, 1'b0);
    check_pred(32'h208, 1'b1);
    issue(S_BNE, 32'h208, 32'd7, 32'd7, 32'h10, 1'b0, 1'b0, 1'b0, 32'h20C, 32'h20C, 1'b0);
    check_pred(32'h208, 1'b0);

    // flushed branch: no redirect, no BHT update
    issue(S_BEQ, 32'h414, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_pred(32'h414, 1'b0);

    // back-to-back mixed operations
    issue(S_BGE,  32'h600, 32'd1, 32'hFFFF_FFFF, 32'h8, 1'b1, 1'b0, 1'b0, 32'h608, 32'h604, 1'b1);
    issue(S_BNE,  32'h700, 32'd3, 32'd4, 32'h10, 1'b0, 1'b0, 1'b1, 32'h710, 32'h704, 1'b1);
    issue(S_BGEU, 32'h704, 32'd1, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 1'b0, 32'h708, 32'h708, 1'b0);
    issue(8'h00,  32'h800, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h804, 1'b0);

    // priority: jal over beq, jalr over jal
    issue(S_JAL | S_BEQ, 32'h900, 32'd1, 32'd2, 32'h10, 1'b0, 1'b0, 1'b1, 32'h910, 32'h904, 1'b1);
    issue(S_JALR | S_JAL, 32'h904, 32'h2000, 32'd0, 32'h5, 1'b0, 1'b0, 1'b1, 32'h2004, 32'h908, 1'b1);

    // address wrap modulo 2^32
    issue(S_BEQ, 32'hFFFF_FFF0, 32'd9, 32'd9, 32'h20, 1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFF4, 1'b1);
    idle();
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches_o, 32'd13);
    check("stat_mispredicts", stat_mispredicts_o, 32'd6);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
